// File: rtl/key_event_arbiter.sv
// key_event_arbiter: qualifies held key presses and offers them one at a time, round-robin
module key_event_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keys,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    output logic [3:0] overrun
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t state, state_n;
    logic [3:0][CW-1:0] cnt, cnt_n;
    logic [3:0] press, pending, pending_n, overrun_n, clr;
    logic [1:0] last_grant, last_grant_n, grant, idx, evt_id_n;
    logic found, hs;

    // hold counters saturate while held and clear on release; a press fires once per run
    always_comb begin
        cnt_n = cnt;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = keys[i] && cnt[i] == HOLD_LAST;
            cnt_n[i] = !keys[i] ? '0 : cnt[i] == HOLD_MAX ? cnt[i] : cnt[i] + 1'b1;
        end
    end

    // pending bits: a press sets, an accepted offer clears; a press onto an unaccepted one overruns
    always_comb begin
        hs = state == OFFER && evt_ready;
        clr = hs ? 4'b0001 << evt_id : 4'b0000;
        pending_n = press | (pending & ~clr);
        overrun_n = overrun | (press & pending & ~clr);
    end

    // round-robin pick: first pending key after the last granted one, wrapping
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx = '0;
        for (int j = 0; j < 4; j++) begin
            idx = last_grant + 2'(j) + 2'd1;
            if (!found && pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // offer FSM: IDLE latches a grant, OFFER waits for the handshake
    always_comb begin
        state_n = state == IDLE ? (found ? OFFER : IDLE) : (evt_ready ? IDLE : OFFER);
        evt_id_n = state == IDLE && found ? grant : evt_id;
        last_grant_n = hs ? evt_id : last_grant;
    end

    // state registers; last_grant resets to 3 so key 0 is scanned first
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            evt_id <= '0;
            last_grant <= 2'd3;
            pending <= '0;
            overrun <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            evt_id <= evt_id_n;
            last_grant <= last_grant_n;
            pending <= pending_n;
            overrun <= overrun_n;
            cnt <= cnt_n;
        end
    end

    assign evt_valid = state == OFFER;
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: vector table plus hand sequences, event ids checked through a scoreboard
module tb_key_event_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic evt_ready = 1'b0;
    logic [3:0] keys = 4'h0;
    logic evt_valid;
    logic [1:0] evt_id;
    logic [3:0] overrun;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic r;
        logic [3:0] k;
        logic rd;
        logic ev;
        logic [1:0] eid;
        logic [3:0] eo;
        logic push;
    } vec_t;

    vec_t vecs[$];
    logic [1:0] sb[$];

    key_event_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .keys(keys),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_id(evt_id),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int r, int k, int rd, int ev, int eid, int eo, int push);
        vec_t v;
        v.r = 1'(r);
        v.k = 4'(k);
        v.rd = 1'(rd);
        v.ev = 1'(ev);
        v.eid = 2'(eid);
        v.eo = 4'(eo);
        v.push = 1'(push);
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addn(int n, int r, int k, int rd, int ev, int eid, int eo, int push);
        for (int i = 0; i < n; i++) vecs.push_back(mk(r, k, rd, ev, eid, eo, (push != 0 && i == 0) ? 1 : 0));
    endtask

    task automatic cyc(vec_t v, string tag);
        @(negedge clk);
        reset = v.r;
        keys = v.k;
        evt_ready = v.rd;
        if (v.push) sb.push_back(v.eid);
        if (!v.r && evt_valid && v.rd) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s unexpected event: got id %0d expected none", tag, evt_id);
            end else begin
                check({tag, " accepted id"}, int'(evt_id), int'(sb.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        check({tag, " evt_valid"}, int'(evt_valid), int'(v.ev));
        if (v.ev || v.r) check({tag, " evt_id"}, int'(evt_id), int'(v.eid));
        check({tag, " overrun"}, int'(overrun), int'(v.eo));
    endtask

    task automatic hand(int n, int r, int k, int rd, int ev, int eid, int eo, int push, string tag);
        for (int i = 0; i < n; i++) cyc(mk(r, k, rd, ev, eid, eo, (push != 0 && i == 0) ? 1 : 0), tag);
    endtask

    initial begin
        // single key held 6 cycles; keys high during reset must not count
        addn(1, 1, 4'h0, 1, 0, 0, 0, 0);
        addn(1, 1, 4'h1, 1, 0, 0, 0, 0);
        addn(4, 0, 4'h1, 1, 0, 0, 0, 0);
        addn(1, 0, 4'h1, 1, 1, 0, 0, 1);
        addn(1, 0, 4'h1, 1, 0, 0, 0, 0);
        addn(3, 0, 4'h0, 1, 0, 0, 0, 0);
        // bounce on key 1: only the 4-cycle run qualifies
        addn(3, 0, 4'h2, 1, 0, 0, 0, 0);
        addn(1, 0, 4'h0, 1, 0, 0, 0, 0);
        addn(4, 0, 4'h2, 1, 0, 0, 0, 0);
        addn(1, 0, 4'h0, 1, 1, 1, 0, 1);
        addn(2, 0, 4'h0, 1, 0, 0, 0, 0);
        // all four keys together after reset: ids 0..3, valid every other cycle
        addn(1, 1, 4'h0, 1, 0, 0, 0, 0);
        addn(4, 0, 4'hF, 1, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            addn(1, 0, 4'hF, 1, 1, j, 0, 1);
            addn(1, 0, 4'hF, 1, 0, 0, 0, 0);
        end
        addn(1, 0, 4'h0, 1, 0, 0, 0, 0);
        // id 2 stalled 10 cycles, then accepted on first ready
        addn(4, 0, 4'h4, 0, 0, 0, 0, 0);
        addn(1, 0, 4'h4, 0, 1, 2, 0, 1);
        addn(9, 0, 4'h4, 0, 1, 2, 0, 0);
        addn(1, 0, 4'h4, 1, 0, 0, 0, 0);
        addn(2, 0, 4'h0, 1, 0, 0, 0, 0);
        foreach (vecs[i]) cyc(vecs[i], $sformatf("row%0d", i));

        // key 3 re-pressed while stalled: overrun, one event; later press after acceptance re-pends
        hand(4, 0, 4'h8, 0, 0, 0, 0, 0, "ovr");
        hand(1, 0, 4'h0, 0, 1, 3, 0, 1, "ovr");
        hand(3, 0, 4'h8, 0, 1, 3, 0, 0, "ovr");
        hand(1, 0, 4'h8, 0, 1, 3, 8, 0, "ovr");
        hand(1, 0, 4'h0, 0, 1, 3, 8, 0, "ovr");
        hand(3, 0, 4'h0, 1, 0, 0, 8, 0, "ovr");
        hand(4, 0, 4'h8, 1, 0, 0, 8, 0, "ovr");
        hand(1, 0, 4'h8, 1, 1, 3, 8, 1, "ovr");
        hand(1, 0, 4'h0, 1, 0, 0, 8, 0, "ovr");

        // key 0 press lands on the accepting edge: stays pending, no overrun
        hand(4, 0, 4'h1, 0, 0, 0, 8, 0, "same");
        hand(1, 0, 4'h0, 0, 1, 0, 8, 1, "same");
        hand(3, 0, 4'h1, 0, 1, 0, 8, 0, "same");
        hand(1, 0, 4'h1, 1, 0, 0, 8, 0, "same");
        hand(1, 0, 4'h0, 1, 1, 0, 8, 1, "same");
        hand(1, 0, 4'h0, 1, 0, 0, 8, 0, "same");

        // reset during an offer, then key 0 regains priority
        hand(4, 0, 4'h2, 0, 0, 0, 8, 0, "rst");
        hand(1, 0, 4'h2, 0, 1, 1, 8, 0, "rst");
        hand(1, 1, 4'h2, 1, 0, 0, 0, 0, "rst");
        hand(4, 0, 4'hF, 1, 0, 0, 0, 0, "rst");
        for (int j = 0; j < 4; j++) begin
            hand(1, 0, 4'hF, 1, 1, j, 0, 1, "rst");
            hand(1, 0, 4'hF, 1, 0, 0, 0, 0, "rst");
        end
        hand(1, 0, 4'h0, 1, 0, 0, 0, 0, "rst");

        check("scoreboard drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: consecutive high samples required to qualify a press; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port keys, input, 4 bits: already-stabilized key levels, one bit per key, high = pressed.
REQ-005 SHALL have port evt_ready, input, 1 bit: downstream accepts the offered event.
REQ-006 SHALL have port evt_valid, output, 1 bit: an event is offered.
REQ-007 SHALL have port evt_id, output, 2 bits: index of the key whose event is offered.
REQ-008 SHALL have port overrun, output, 4 bits: sticky per-key flag marking a press lost while the previous one was still pending.

Function
REQ-009 SHALL keep one hold counter per key, width clog2(HOLD_CYCLES+1): +1 each edge keys[i]=1, saturating at HOLD_CYCLES; cleared to 0 on any edge keys[i]=0.
REQ-010 SHALL raise a press event for key i on the edge where keys[i]=1 and counter[i]=HOLD_CYCLES-1: exactly one event per press; no further event until keys[i] has been sampled low.
REQ-011 SHALL set pending[i] on the same edge as the press event.
REQ-012 SHALL, on a press event for key i while pending[i] is already set and not cleared that edge, keep pending[i] set and set overrun[i].
REQ-013 SHALL, on a press event for key i on the same edge its event is accepted, leave pending[i] set with no overrun.
REQ-014 SHALL implement a two-state FSM: IDLE and OFFER.
REQ-015 SHALL, in IDLE with any pending bit set, register evt_id from the round-robin choice, set evt_valid=1, go to OFFER; otherwise stay in IDLE with evt_valid=0.
REQ-016 SHALL scan round-robin from (last_grant+1) mod 4 upward with wrap-around; the first set pending bit wins.
REQ-017 SHALL, in OFFER, hold evt_valid=1 and evt_id stable while evt_ready=0, with no time limit.
REQ-018 SHALL, in OFFER with evt_ready=1 (handshake), clear pending[evt_id], set last_grant=evt_id, drop evt_valid, and return to IDLE.
REQ-019 SHALL NOT affect the FSM by evt_ready while evt_valid=0.
REQ-020 SHALL deliver at most one event per two cycles; evt_valid is low for at least one cycle between events.
REQ-021 SHALL assert evt_valid no earlier than HOLD_CYCLES+1 edges after keys[i] is first sampled high (no competing pending, FSM in IDLE).
REQ-022 SHALL process all four keys concurrently; simultaneous press events all set pending on the same edge.

Reset
REQ-023 SHALL, on any edge with reset=1, clear all counters, pending and overrun bits, evt_valid=0, evt_id=0, FSM=IDLE, and last_grant=3 so key 0 wins first; this applies mid-offer too.
REQ-024 SHALL ignore keys and evt_ready on reset edges; counting starts on the first edge after reset deasserts.
REQ-025 SHALL clear overrun only by reset.

Verification
REQ-026 SHALL verify, with HOLD_CYCLES=4 and evt_ready=1: keys=0001 held 6 cycles -> evt_valid high for 1 cycle with evt_id=0, 5 edges after the first high sample; no second event.
REQ-027 SHALL verify a bounce: keys[1] high 3 cycles, low 1, high 4 -> exactly one event, id=1, after the 4-cycle run only.
REQ-028 SHALL verify keys=1111 qualifying together with evt_ready=1 -> ids 0,1,2,3 in that order, evt_valid high every other cycle.
REQ-029 SHALL verify evt_ready=0 for 10 cycles while id=2 is offered -> evt_valid and evt_id=2 stable throughout; accepted on the first ready cycle.
REQ-030 SHALL verify that key 3 pressed, released and pressed again while its first event is stalled -> overrun=1000, a single id=3 event after ready, and pending re-sets only if the second press arrives after acceptance.
REQ-031 SHALL verify reset asserted during OFFER -> evt_valid=0, overrun=0000, and after release the next grant is key 0 priority.
